// File: rtl/hitmux_sel_sequencer.sv
// Purpose: pops combination records and steps the hitmux select so each 5/5 record yields five 4/5 words.
// Latency: one edge from pop (fifo_rd) to the first valid word; 4/5 and ee records stream one per cycle.
// Backpressure: out_hold freezes popping and sel stepping; sequencing resumes at the next sel on release.
module hitmux_sel_sequencer #(
  parameter int CW   = 111,
  parameter int ZW   = 12,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fifo_empty,
  output logic            fifo_rd,
  input  logic [CW-1:0]   fifo_comb,
  input  logic [ZW-1:0]   fifo_zeta,
  input  logic            fifo_last,
  input  logic            fifo_ee,
  input  logic            fifo_xftlast,
  input  logic            fifo_is45,
  input  logic            out_hold,
  output logic [CW-1:0]   comb_out,
  output logic [ZW-1:0]   zeta_out,
  output logic            last_out,
  output logic            ee_out,
  output logic            xftlast_out,
  output logic            is45_out,
  output logic [2:0]      sel,
  output logic            out_valid,
  output logic [CNTW-1:0] subcomb_cnt
);

  // Words still to emit for the record currently held on the outputs.
  logic [2:0] remain;
  logic       rec_last;
  logic       load;
  logic       emit;

  assign load    = (remain == 3'd0) && !fifo_empty && !out_hold;
  assign emit    = (remain != 3'd0) && !out_hold;
  assign fifo_rd = load && !reset;

  // The last flag belongs only to the final word of a record: sel 5 (4/5 or last variant) or sel 0 (ee).
  assign last_out = rec_last & ((sel == 3'b101) | (sel == 3'b000));

  // Record capture, select stepping and the emitted-word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      comb_out    <= '0;
      zeta_out    <= '0;
      rec_last    <= 1'b0;
      ee_out      <= 1'b0;
      xftlast_out <= 1'b0;
      is45_out    <= 1'b0;
      sel         <= 3'b000;
      remain      <= 3'd0;
      out_valid   <= 1'b0;
      subcomb_cnt <= '0;
    end else if (load) begin
      comb_out    <= fifo_comb;
      zeta_out    <= fifo_zeta;
      rec_last    <= fifo_last;
      ee_out      <= fifo_ee;
      xftlast_out <= fifo_xftlast;
      is45_out    <= fifo_is45;
      out_valid   <= 1'b1;
      subcomb_cnt <= subcomb_cnt + 1'b1;
      // An end-event word outranks the 5/5 flag: it is always a single sel-0 word.
      if (fifo_ee) begin
        sel    <= 3'b000;
        remain <= 3'd0;
      end else if (fifo_is45) begin
        sel    <= 3'b001;
        remain <= 3'd4;
      end else begin
        sel    <= 3'b101;
        remain <= 3'd0;
      end
    end else if (emit) begin
      sel         <= sel + 3'd1;
      remain      <= remain - 3'd1;
      out_valid   <= 1'b1;
      subcomb_cnt <= subcomb_cnt + 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hitmux_sel_sequencer.sv
// Directed bench: per-cycle vector table for the sequencing cases, then a hand-written counter wrap run.
// Inputs change 1 time unit after the rising edge; fifo_rd is sampled just before the next edge.
// Registered outputs are sampled 1 time unit after the edge.
module tb_hitmux_sel_sequencer;

  localparam int CW   = 111;
  localparam int ZW   = 12;
  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            fifo_empty;
  logic            fifo_rd;
  logic [CW-1:0]   fifo_comb;
  logic [ZW-1:0]   fifo_zeta;
  logic            fifo_last;
  logic            fifo_ee;
  logic            fifo_xftlast;
  logic            fifo_is45;
  logic            out_hold;
  logic [CW-1:0]   comb_out;
  logic [ZW-1:0]   zeta_out;
  logic            last_out;
  logic            ee_out;
  logic            xftlast_out;
  logic            is45_out;
  logic [2:0]      sel;
  logic            out_valid;
  logic [CNTW-1:0] subcomb_cnt;

  hitmux_sel_sequencer #(.CW(CW), .ZW(ZW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_comb(fifo_comb), .fifo_zeta(fifo_zeta), .fifo_last(fifo_last),
    .fifo_ee(fifo_ee), .fifo_xftlast(fifo_xftlast), .fifo_is45(fifo_is45),
    .out_hold(out_hold), .comb_out(comb_out), .zeta_out(zeta_out),
    .last_out(last_out), .ee_out(ee_out), .xftlast_out(xftlast_out),
    .is45_out(is45_out), .sel(sel), .out_valid(out_valid), .subcomb_cnt(subcomb_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, empty, is45, ee, last, hold;
    logic [7:0] comb;
    logic       e_rd, e_valid;
    logic [2:0] e_sel;
    logic       e_last, e_ee;
    logic [7:0] e_comb;
    logic [15:0] e_cnt;
    logic       e_is45;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  // Full-width record fields are derived from one tag byte so high bits are exercised too.
  function automatic logic [CW-1:0] comb_of(input logic [7:0] t);
    return {t, 95'h0, t};
  endfunction

  task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, empty, is45, ee, last, hold, input logic [7:0] comb,
                     input logic e_rd, e_valid, input logic [2:0] e_sel, input logic e_last, e_ee,
                     input logic [7:0] e_comb, input logic [15:0] e_cnt, input logic e_is45);
    vec_t v;
    v.rst = rst; v.empty = empty; v.is45 = is45; v.ee = ee; v.last = last; v.hold = hold;
    v.comb = comb; v.e_rd = e_rd; v.e_valid = e_valid; v.e_sel = e_sel; v.e_last = e_last;
    v.e_ee = e_ee; v.e_comb = e_comb; v.e_cnt = e_cnt; v.e_is45 = e_is45;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, empty, is45, ee, last, hold, input logic [7:0] comb);
    reset        = rst;
    fifo_empty   = empty;
    fifo_is45    = is45;
    fifo_ee      = ee;
    fifo_last    = last;
    out_hold     = hold;
    fifo_comb    = comb_of(comb);
    fifo_zeta    = {4'h0, comb};
    fifo_xftlast = comb[0];
  endtask

  initial begin
    int rd_seen;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    //   rst emp 45 ee lst hold comb  | rd val sel lst ee comb cnt 45
    // Reset with a record waiting: no pop, everything zero.
    add(1, 0, 1, 0, 1, 0, 8'hA1,  0, 0, 3'd0, 0, 0, 8'h00, 16'd0, 0);
    // Single 5/5 record, last: sel 1..5, last only on sel 5; FIFO empties right after the pop.
    add(0, 0, 1, 0, 1, 0, 8'hA1,  1, 1, 3'd1, 0, 0, 8'hA1, 16'd1, 1);
    add(0, 1, 0, 0, 0, 0, 8'h00,  0, 1, 3'd2, 0, 0, 8'hA1, 16'd2, 1);
    add(0, 1, 0, 0, 0, 0, 8'h00,  0, 1, 3'd3, 0, 0, 8'hA1, 16'd3, 1);
    add(0, 1, 0, 0, 0, 0, 8'h00,  0, 1, 3'd4, 0, 0, 8'hA1, 16'd4, 1);
    add(0, 1, 0, 0, 0, 0, 8'h00,  0, 1, 3'd5, 1, 0, 8'hA1, 16'd5, 1);
    add(0, 1, 0, 0, 0, 0, 8'h00,  0, 0, 3'd5, 1, 0, 8'hA1, 16'd5, 1);
    // Three back-to-back 4/5 records.
    add(0, 0, 0, 0, 0, 0, 8'hB1,  1, 1, 3'd5, 0, 0, 8'hB1, 16'd6, 0);
    add(0, 0, 0, 0, 0, 0, 8'hB2,  1, 1, 3'd5, 0, 0, 8'hB2, 16'd7, 0);
    add(0, 0, 0, 0, 1, 0, 8'hB3,  1, 1, 3'd5, 1, 0, 8'hB3, 16'd8, 0);
    add(0, 1, 0, 0, 0, 0, 8'h00,  0, 0, 3'd5, 1, 0, 8'hB3, 16'd8, 0);
    // End-event word with is45 also set: one sel-0 word.
    add(0, 0, 1, 1, 0, 0, 8'hC1,  1, 1, 3'd0, 0, 1, 8'hC1, 16'd9, 1);
    add(0, 1, 0, 0, 0, 0, 8'h00,  0, 0, 3'd0, 0, 1, 8'hC1, 16'd9, 1);
    // Hold while idle with a record waiting: no pop until release.
    add(0, 0, 0, 0, 0, 1, 8'hD1,  0, 0, 3'd0, 0, 1, 8'hC1, 16'd9, 1);
    add(0, 0, 0, 0, 0, 0, 8'hD1,  1, 1, 3'd5, 0, 0, 8'hD1, 16'd10, 0);
    // 5/5 record with hold in the two cycles after the pop, next record waiting throughout.
    add(0, 0, 1, 0, 1, 0, 8'hE1,  1, 1, 3'd1, 0, 0, 8'hE1, 16'd11, 1);
    add(0, 0, 0, 0, 0, 1, 8'hF1,  0, 0, 3'd1, 0, 0, 8'hE1, 16'd11, 1);
    add(0, 0, 0, 0, 0, 1, 8'hF1,  0, 0, 3'd1, 0, 0, 8'hE1, 16'd11, 1);
    add(0, 0, 0, 0, 0, 0, 8'hF1,  0, 1, 3'd2, 0, 0, 8'hE1, 16'd12, 1);
    add(0, 0, 0, 0, 0, 0, 8'hF1,  0, 1, 3'd3, 0, 0, 8'hE1, 16'd13, 1);
    add(0, 0, 0, 0, 0, 0, 8'hF1,  0, 1, 3'd4, 0, 0, 8'hE1, 16'd14, 1);
    add(0, 0, 0, 0, 0, 0, 8'hF1,  0, 1, 3'd5, 1, 0, 8'hE1, 16'd15, 1);
    add(0, 0, 0, 0, 0, 0, 8'hF1,  1, 1, 3'd5, 0, 0, 8'hF1, 16'd16, 0);
    add(0, 1, 0, 0, 0, 0, 8'h00,  0, 0, 3'd5, 0, 0, 8'hF1, 16'd16, 0);
    // Reset at sel 3 of a 5/5 record; the waiting record is then emitted fresh.
    add(0, 0, 1, 0, 1, 0, 8'h61,  1, 1, 3'd1, 0, 0, 8'h61, 16'd17, 1);
    add(0, 0, 0, 0, 0, 0, 8'h7E,  0, 1, 3'd2, 0, 0, 8'h61, 16'd18, 1);
    add(0, 0, 0, 0, 0, 0, 8'h7E,  0, 1, 3'd3, 0, 0, 8'h61, 16'd19, 1);
    add(1, 0, 0, 0, 0, 0, 8'h7E,  0, 0, 3'd0, 0, 0, 8'h00, 16'd0, 0);
    add(0, 0, 0, 0, 0, 0, 8'h7E,  1, 1, 3'd5, 0, 0, 8'h7E, 16'd1, 0);
    add(0, 1, 0, 0, 0, 0, 8'h00,  0, 0, 3'd5, 0, 0, 8'h7E, 16'd1, 0);
    // Reset while idle with a record waiting: reset must block the pop.
    add(1, 0, 0, 0, 0, 0, 8'h3C,  0, 0, 3'd0, 0, 0, 8'h00, 16'd0, 0);
    add(0, 0, 0, 0, 0, 0, 8'h3C,  1, 1, 3'd5, 0, 0, 8'h3C, 16'd1, 0);

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].empty, vecs[i].is45, vecs[i].ee, vecs[i].last, vecs[i].hold, vecs[i].comb);
      #3;
      chk("fifo_rd", i, fifo_rd, vecs[i].e_rd);
      @(posedge clk);
      #1;
      chk("out_valid", i, out_valid, vecs[i].e_valid);
      chk("sel", i, sel, vecs[i].e_sel);
      chk("last_out", i, last_out, vecs[i].e_last);
      chk("ee_out", i, ee_out, vecs[i].e_ee);
      chk("is45_out", i, is45_out, vecs[i].e_is45);
      chk("comb_out", i, comb_out, comb_of(vecs[i].e_comb));
      chk("zeta_out", i, zeta_out, {4'h0, vecs[i].e_comb});
      chk("xftlast_out", i, xftlast_out, vecs[i].e_comb[0]);
      chk("subcomb_cnt", i, subcomb_cnt, vecs[i].e_cnt);
    end

    // Counter wrap: 65535 4/5 records stream back to back, one more wraps the count to 0.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    chk("wrap_reset_cnt", 0, subcomb_cnt, 16'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55);
    rd_seen = 0;
    for (int n = 1; n <= 65536; n++) begin
      #3;
      if (fifo_rd) rd_seen++;
      @(posedge clk);
      #1;
      if (n == 65535) chk("wrap_cnt_max", n, subcomb_cnt, 16'hFFFF);
    end
    chk("wrap_cnt_zero", 65536, subcomb_cnt, 16'd0);
    chk("wrap_valid", 65536, out_valid, 1'b1);
    chk("wrap_pops", 65536, rd_seen, 65536);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    chk("wrap_idle_valid", 65537, out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hitmux_sel_sequencer.md
# hitmux_sel_sequencer

Sequencer directly upstream of `hitmux_55_to_45`. Pops combination records from the combination FIFO (first-word-fall-through) and holds each record on its outputs. It steps the mux select so that:
- a 5/5 combination is presented once per 4/5 variant (sel 1..5);
- a 4/5 combination is presented once;
- an end-event word is presented once.

It asserts a valid strobe on each presented word so the downstream fit stage captures the muxed word. It honours downstream backpressure.

## Interface
Parameters:
- `CW`, 111, combination hit-data width (`comb_in`/`comb_out`).
- `ZW`, 12, zeta field width.
- `CNTW`, 16, width of sub-combination counter.

Ports:
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `fifo_empty` input 1: combination FIFO empty; `fifo_*` data valid when low.
- `fifo_rd` output 1: pop strobe, combinational; one record per high cycle.
- `fifo_comb` input CW: hit data of head record.
- `fifo_zeta` input ZW: zeta field of head record.
- `fifo_last` input 1: last combination of road.
- `fifo_ee` input 1: head is end-event word.
- `fifo_xftlast` input 1: XFT-last flag.
- `fifo_is45` input 1: record is 5/5, expand to five 4/5 variants.
- `out_hold` input 1: downstream almost-full; freezes sequencing.
- `comb_out` output CW: registered hit data of current record.
- `zeta_out` output ZW: registered zeta field.
- `last_out` output 1: last flag, qualified (see Operation).
- `ee_out` output 1: end-event flag of current record.
- `xftlast_out` output 1: registered XFT-last flag.
- `is45_out` output 1: registered is_45 flag.
- `sel` output 3: mux select, registered.
- `out_valid` output 1: current sel/record word is new this cycle; capture once.
- `subcomb_cnt` output CNTW: count of valid words emitted, wraps.

## Operation
- Internal state:
  - record registers (drive `*_out`);
  - `next_sel` [2:0];
  - `remain` [2:0] = words still to emit for the loaded record;
  - `loaded` bit.
- Load edge: condition `remain==0 && !fifo_empty && !out_hold`.
  - `fifo_rd=1` in that cycle.
  - Record registers capture the `fifo_*` fields.
  - The first word is emitted on the same edge.
- First-word `sel` and `remain` after the load edge:
  - `fifo_ee=1`: `sel=3'b000`, `remain=0`. `ee` takes priority over `is45`.
  - `fifo_is45=1`: `sel=3'b001`, `remain=4`.
  - otherwise: `sel=3'b101`, `remain=0`.
- Emit edge for an expanding record: condition `remain!=0 && !out_hold`.
  - `sel<=sel+1`, `remain<=remain-1`, `out_valid<=1`.
- `out_valid<=0` on any edge that neither loads nor emits.
  - `sel` and the record registers are held on such edges.
- `fifo_rd = (remain==0) && !fifo_empty && !out_hold && !reset`.
- `last_out = rec_last & (sel==3'b101 | sel==3'b000)`. Last is asserted only on the final word of a record.
- `subcomb_cnt` increments by 1 on every edge that sets `out_valid=1`. It wraps at 2^CNTW.
- Reset, at any time including mid-expansion:
  - `out_valid=0`, `sel=0`, `remain=0`, `subcomb_cnt=0`;
  - all `*_out` = 0, `fifo_rd=0`;
  - the partly emitted record is discarded and not re-popped.

## Timing
- Pop-to-valid latency: 1 edge. `fifo_rd` high in cycle t gives `out_valid=1` with the first `sel` in cycle t+1.
- Throughput:
  - 4/5 or ee records: 1 per cycle, back-to-back with no bubble (reload allowed on the edge after the final word).
  - 5/5 records: 5 cycles each.
- Hold:
  - `out_hold` high in cycle t: `out_valid=0` in t+1, no pop in t, `sel` unchanged.
  - On release, sequencing resumes at the next `sel`. No word is skipped or duplicated.
- `fifo_empty` with `remain==0`: idle, `out_valid=0`, outputs hold the last record.
- `fifo_empty` rising during an expansion does not affect the remaining words.

## Test plan
- Single 5/5 record (`is45=1`, `last=1`), no hold → `fifo_rd` one cycle, then `out_valid` 5 consecutive cycles with sel 1,2,3,4,5. `last_out` high only with sel=5. `subcomb_cnt=5`.
- Three back-to-back 4/5 records → three `fifo_rd` in consecutive cycles. `out_valid` high 3 consecutive cycles, sel=5 each, `comb_out` tracks each record.
- ee word (`ee=1`, `is45=1`) → one `out_valid` with sel=0, `ee_out=1`, `remain` stays 0.
- 5/5 record with `out_hold` high during cycles 2–3 after the pop → valid words sel 1, (gap, gap), 2, 3, 4, 5. No pop during the hold. Exactly 5 valid words.
- `reset` pulsed while sel=3 of a 5/5 record → next cycle all outputs 0, `subcomb_cnt=0`. The next FIFO record is emitted fresh, with no residual sel 4/5.
- `subcomb_cnt` preset by 65535 emissions, one more 4/5 record → count wraps to 0.
